// File: rtl/scfifo_pkg.sv
// Shared types and helpers for the single-clock FIFO family.
package scfifo_pkg;

    typedef enum logic [1:0] {
        RAM_LAT_1 = 2'd1,
        RAM_LAT_2 = 2'd2
    } ram_lat_t;

    localparam int unsigned CNT_EXTRA_BITS = 1;
    localparam int unsigned PTR_FN_W       = 16;

    function automatic int unsigned cnt_width(input int unsigned log_depth);
        return log_depth + CNT_EXTRA_BITS;
    endfunction

    function automatic ram_lat_t to_ram_lat(input int unsigned lat);
        return (lat == 2) ? RAM_LAT_2 : RAM_LAT_1;
    endfunction

    // Pointers wrap at the configured capacity, which need not be a power of two.
    function automatic logic [PTR_FN_W-1:0] wrap_inc(input logic [PTR_FN_W-1:0] ptr,
                                                     input int unsigned num_words);
        return (ptr == PTR_FN_W'(num_words - 1)) ? '0 : ptr + PTR_FN_W'(1);
    endfunction

endpackage

// File: rtl/generic_m20k.sv
// Simple dual-port block RAM: one write port, one read port, optional output register.
module generic_m20k #(
    parameter int unsigned WIDTH           = 20,
    parameter int unsigned ADDR_W          = 5,
    parameter int unsigned NUM_WORDS       = 32,
    parameter int unsigned READ_OUTPUT_REG = 0,
    parameter string       FAMILY          = "Agilex"
) (
    input  logic              clk_i,
    input  logic              wren_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              rden_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [NUM_WORDS];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (wren_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rden_i) rd_q <= mem_q[raddr_i];
    end

    if (READ_OUTPUT_REG != 0) begin : g_oreg
        logic [WIDTH-1:0] oreg_q;
        always_ff @(posedge clk_i) oreg_q <= rd_q;
        assign rdata_o = oreg_q;
    end else begin : g_noreg
        assign rdata_o = rd_q;
    end

endmodule

// File: rtl/scfifo_sa_prefetch.sv
// Show-ahead output stage: output register plus skid buffer absorbing RAM read latency.
module scfifo_sa_prefetch
    import scfifo_pkg::*;
#(
    parameter int unsigned WIDTH       = 20,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             sclr_i,
    input  logic             ram_avail_i,
    input  logic [WIDTH-1:0] ram_data_i,
    input  logic             rd_ok_i,
    output logic             rd_issue_o,
    output logic [WIDTH-1:0] q_o,
    output logic             empty_o
);

    localparam int unsigned SKID = RAM_LATENCY;
    localparam int unsigned OCC_W = 3;

    logic [RAM_LATENCY-1:0] pend_q, pend_d;
    logic [WIDTH-1:0]       skid_q [SKID];
    logic [WIDTH-1:0]       skid_d [SKID];
    logic [1:0]             skid_cnt_q, skid_cnt_d;
    logic [WIDTH-1:0]       out_q, out_d;
    logic                   out_vld_q, out_vld_d;
    logic                   in_valid, take, push;
    logic [OCC_W-1:0]       occ;

    assign in_valid = pend_q[RAM_LATENCY-1];

    // Credit counts in-flight reads plus buffered words after this cycle's pop,
    // so a full-rate stream keeps issuing without bubbles or drops.
    assign occ = OCC_W'($countones(pend_q)) + OCC_W'(out_vld_q) + OCC_W'(skid_cnt_q)
               - OCC_W'(rd_ok_i);
    assign rd_issue_o = ram_avail_i & (occ < OCC_W'(RAM_LATENCY + 1));

    always_comb begin
        pend_d     = RAM_LATENCY'({pend_q, rd_issue_o});
        skid_d     = skid_q;
        skid_cnt_d = skid_cnt_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        take       = ~out_vld_q | rd_ok_i;
        push       = in_valid;
        if (take) begin
            if (skid_cnt_q != 2'd0) begin
                out_d     = skid_q[0];
                out_vld_d = 1'b1;
                for (int unsigned i = 0; i + 1 < SKID; i++) skid_d[i] = skid_q[i + 1];
                skid_cnt_d = skid_cnt_q - 2'd1;
            end else if (in_valid) begin
                out_d     = ram_data_i;
                out_vld_d = 1'b1;
                push      = 1'b0;
            end else begin
                out_vld_d = 1'b0;
            end
        end
        if (push) begin
            for (int unsigned i = 0; i < SKID; i++) begin
                if (2'(i) == skid_cnt_d) skid_d[i] = ram_data_i;
            end
            skid_cnt_d = skid_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q     <= '0;
            skid_cnt_q <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            for (int unsigned i = 0; i < SKID; i++) skid_q[i] <= '0;
        end else if (sclr_i) begin
            pend_q     <= '0;
            skid_cnt_q <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            for (int unsigned i = 0; i < SKID; i++) skid_q[i] <= '0;
        end else begin
            pend_q     <= pend_d;
            skid_cnt_q <= skid_cnt_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
        end
    end

    assign q_o     = out_q;
    assign empty_o = ~out_vld_q;

endmodule

// File: rtl/scfifo_showahead.sv
// Single-clock show-ahead FIFO: q holds the head word whenever empty is low.
module scfifo_showahead
    import scfifo_pkg::*;
#(
    parameter int unsigned LOG_DEPTH               = 5,
    parameter int unsigned NUM_WORDS               = 2**LOG_DEPTH,
    parameter int unsigned WIDTH                   = 20,
    parameter int unsigned RAM_LATENCY             = 1,
    parameter int unsigned ALLOW_RWCYCLE_WHEN_FULL = 0,
    parameter string       FAMILY                  = "Agilex"
) (
    input  logic               clock,
    input  logic               aclr_n,
    input  logic               sclr,
    input  logic [WIDTH-1:0]   data,
    input  logic               wrreq,
    input  logic               rdreq,
    input  logic [LOG_DEPTH:0] af_thresh,
    input  logic [LOG_DEPTH:0] ae_thresh,
    output logic [WIDTH-1:0]   q,
    output logic [LOG_DEPTH:0] usedw,
    output logic               empty,
    output logic               full,
    output logic               almost_empty,
    output logic               almost_full,
    output logic               overflow,
    output logic               underflow
);

    localparam int unsigned CW  = cnt_width(LOG_DEPTH);
    localparam ram_lat_t    LAT = to_ram_lat(RAM_LATENCY);

    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        ram_cnt_q, ram_cnt_d, usedw_q, usedw_d;
    logic                 full_q, af_q, ae_q, ovf_q, unf_q;
    logic                 wr_ok, rd_ok, rd_issue;
    logic [WIDTH-1:0]     ram_rdata;

    assign rd_ok = rdreq & ~empty;
    assign wr_ok = wrreq & (~full_q | ((ALLOW_RWCYCLE_WHEN_FULL != 0) & rd_ok));

    always_comb begin
        wr_ptr_d  = wr_ok    ? LOG_DEPTH'(wrap_inc(PTR_FN_W'(wr_ptr_q), NUM_WORDS)) : wr_ptr_q;
        rd_ptr_d  = rd_issue ? LOG_DEPTH'(wrap_inc(PTR_FN_W'(rd_ptr_q), NUM_WORDS)) : rd_ptr_q;
        ram_cnt_d = ram_cnt_q + CW'(wr_ok) - CW'(rd_issue);
        usedw_d   = usedw_q + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            usedw_q   <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else if (sclr) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            usedw_q   <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            usedw_q   <= usedw_d;
            full_q    <= (usedw_d == CW'(NUM_WORDS));
            af_q      <= (usedw_d >= af_thresh);
            ae_q      <= (usedw_d < ae_thresh);
            ovf_q     <= ovf_q | (wrreq & ~wr_ok);
            unf_q     <= unf_q | (rdreq & ~rd_ok);
        end
    end

    generic_m20k #(
        .WIDTH          (WIDTH),
        .ADDR_W         (LOG_DEPTH),
        .NUM_WORDS      (NUM_WORDS),
        .READ_OUTPUT_REG((LAT == RAM_LAT_2) ? 1 : 0),
        .FAMILY         (FAMILY)
    ) u_ram (
        .clk_i  (clock),
        .wren_i (wr_ok),
        .waddr_i(wr_ptr_q),
        .wdata_i(data),
        .rden_i (rd_issue),
        .raddr_i(rd_ptr_q),
        .rdata_o(ram_rdata)
    );

    scfifo_sa_prefetch #(
        .WIDTH      (WIDTH),
        .RAM_LATENCY(RAM_LATENCY)
    ) u_prefetch (
        .clk_i      (clock),
        .rst_n_i    (aclr_n),
        .sclr_i     (sclr),
        .ram_avail_i(ram_cnt_q != '0),
        .ram_data_i (ram_rdata),
        .rd_ok_i    (rd_ok),
        .rd_issue_o (rd_issue),
        .q_o        (q),
        .empty_o    (empty)
    );

    assign usedw        = usedw_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
